// File: rtl/jtframe_dcadd.sv
// jtframe_dcadd
// DC re-insertion stage. Takes signed audio (for example the output of a
// DC-removal filter) and turns it into unsigned samples for a DAC or PWM
// driver. Power-up and mute never pop: while the audio is gated, the output
// ramps linearly between 0 and midscale.
//
// Parameters
//   SW    sample width for din and dout (>= 4)
//   RDIV  log2 of samples per 1-LSB ramp step
//
// Ports
//   clk     system clock
//   rst_n   asynchronous reset, active low
//   sample  one-clock sample strobe; all state advances only when it is high
//   din     signed audio input
//   mute    1 = ramp down to 0, 0 = ramp up and pass audio
//   dout    unsigned audio output, registered
//   ready   high while audio is passing (RUN and zero-cross wait)
//   pdm     1-bit PDM of dout, or constant 0
//
// Optional feature
//   JTFRAME_DCADD_PDM_EN  when defined, pdm is the carry of a first-order
//                         sigma-delta accumulator fed by dout on every clock.
//                         When undefined, pdm is tied to 0.

module jtframe_dcadd #(
    parameter int SW   = 8,
    parameter int RDIV = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sample,
    input  logic [SW-1:0] din,
    input  logic          mute,
    output logic [SW-1:0] dout,
    output logic          ready,
    output logic          pdm
);

    typedef enum logic [2:0] {OFF, UP, RUN, ZCW, DOWN} state_t;

    // RDIV=0 still needs one prescaler bit; with RDIV=0 every sample wraps.
    localparam int            PW        = (RDIV > 0) ? RDIV : 1;
    localparam logic [PW-1:0] PRESC_MAX = {PW{1'b1}};
    localparam logic [SW-1:0] MID       = {1'b1, {(SW-1){1'b0}}};
    localparam logic [SW-1:0] ONE       = SW'(1);

    state_t        st, st_nx;
    logic [SW-1:0] offset, offset_nx;
    logic [PW-1:0] presc, presc_nx;
    logic [7:0]    zct, zct_nx;
    logic [SW-1:0] prevdin;
    logic [SW-1:0] dout_nx;
    logic          ready_nx;

    logic [SW-1:0] audio;
    logic          wrap;
    logic          zc;

    // Adding midscale to a signed sample is exactly an MSB inversion.
    assign audio = {~din[SW-1], din[SW-2:0]};
    assign wrap  = (RDIV == 0) || (presc == PRESC_MAX);
    assign zc    = (din == '0) || (din[SW-1] != prevdin[SW-1]);

    // State and datapath registers, advanced only on sample strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= OFF;
            offset  <= '0;
            presc   <= '0;
            zct     <= '0;
            prevdin <= '0;
            dout    <= '0;
            ready   <= 1'b0;
        end else if (sample) begin
            st      <= st_nx;
            offset  <= offset_nx;
            presc   <= presc_nx;
            zct     <= zct_nx;
            prevdin <= din;
            dout    <= dout_nx;
            ready   <= ready_nx;
        end
    end

    // Next-state logic. A state change keeps the current offset so ramps
    // reverse without a jump; only the UP->RUN and DOWN->OFF exits take
    // their final step on the same update.
    always_comb begin
        st_nx     = st;
        offset_nx = offset;
        presc_nx  = wrap ? '0 : presc + PW'(1);
        zct_nx    = '0;
        dout_nx   = dout;
        ready_nx  = 1'b0;
        case (st)
            OFF: begin
                offset_nx = '0;
                dout_nx   = '0;
                if (!mute) st_nx = UP;
            end
            UP: begin
                if (mute) begin
                    st_nx   = DOWN;
                    dout_nx = offset;
                end else if (offset == MID || (wrap && offset == MID - ONE)) begin
                    st_nx     = RUN;
                    offset_nx = MID;
                    dout_nx   = MID;
                    ready_nx  = 1'b1;
                end else begin
                    offset_nx = wrap ? offset + ONE : offset;
                    dout_nx   = offset_nx;
                end
            end
            RUN: begin
                dout_nx  = audio;
                ready_nx = 1'b1;
                if (mute) st_nx = ZCW;
            end
            ZCW: begin
                if (!mute) begin
                    st_nx    = RUN;
                    dout_nx  = audio;
                    ready_nx = 1'b1;
                end else if (zc || zct == 8'hFF) begin
                    st_nx   = DOWN;
                    dout_nx = offset;
                end else begin
                    zct_nx   = zct + 8'd1;
                    dout_nx  = audio;
                    ready_nx = 1'b1;
                end
            end
            DOWN: begin
                if (!mute) begin
                    st_nx   = UP;
                    dout_nx = offset;
                end else if (offset == '0 || (wrap && offset == ONE)) begin
                    st_nx     = OFF;
                    offset_nx = '0;
                    dout_nx   = '0;
                end else begin
                    offset_nx = wrap ? offset - ONE : offset;
                    dout_nx   = offset_nx;
                end
            end
            default: begin
                st_nx     = OFF;
                offset_nx = '0;
                dout_nx   = '0;
            end
        endcase
        if (st_nx != st) presc_nx = '0;
    end

`ifdef JTFRAME_DCADD_PDM_EN
    logic [SW:0] acc;

    // First-order sigma-delta: the carry out is the PDM bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc <= '0;
        else        acc <= {1'b0, acc[SW-1:0]} + {1'b0, dout};
    end

    assign pdm = acc[SW];
`else
    assign pdm = 1'b0;
`endif

endmodule
